// File: rtl/keypad_pkg.sv
// keypad_pkg: shared scan FSM encoding, index-width helper and autorepeat timing for the keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN   = 2'd0,
    SAMPLE = 2'd1,
    EMIT   = 2'd2
  } scan_state_e;

  localparam int REPEAT_FIRST = 32;
  localparam int REPEAT_NEXT  = 8;

  // Bits needed to index n items; never less than one so that 1-key builds stay legal.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/keypad_evt_fifo.sv
// keypad_evt_fifo: small synchronous first-word-fall-through FIFO with same-cycle push/pop.
module keypad_evt_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             pop, push;

  assign full_o    = (count_q == FULL_CNT);
  assign empty_o   = (count_q == '0);
  assign pop       = rd_en_i && !empty_o;
  // A pop frees the head slot in the same cycle, so a full FIFO can still accept.
  assign push      = wr_en_i && (!full_o || pop);
  assign rd_data_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wr_data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + (AW+1)'(1);
      else if (pop && !push) count_q <= count_q - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: column-scanned ROWSxCOLS keypad with per-key debounce and a press/release event FIFO.
// Define KEYPAD_AUTOREPEAT_EN to add repeated press events for held keys.
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 8,
  parameter int DEBOUNCE   = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ROWS-1:0]              row,
  output logic [COLS-1:0]              col,
  output logic [ROWS*COLS-1:0]         key_state,
  output logic                         evt_valid,
  input  logic                         evt_ready,
  output logic [clog2(ROWS*COLS)-1:0]  evt_code,
  output logic                         evt_press,
  output logic                         overflow,
  input  logic                         ovf_clr
);
  localparam int NK = ROWS * COLS;
  localparam int KW = clog2(NK);
  localparam int RW = clog2(ROWS);
  localparam int CW = clog2(COLS);
  localparam int DW = clog2(SCAN_DIV);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - ROWS - 2);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
  localparam logic [3:0]    DEB_CNT    = 4'(DEBOUNCE);

  scan_state_e     state_q;
  logic [DW-1:0]   dwell_q;
  logic [RW-1:0]   row_idx_q;
  logic [CW-1:0]   col_idx_q, col_idx_d;
  logic [COLS-1:0] col_q;
  logic [ROWS-1:0] sample_q;
  logic [NK-1:0]   key_state_q;
  logic [3:0]      cnt_q [NK];

  logic [KW-1:0]   key_idx;
  logic [3:0]      cnt_inc;
  logic            raw, flip, push, full, empty, evt_pop, drop;
  logic            overflow_q, overflow_d;
  logic [KW:0]     push_data, head;

  always_comb begin
    key_idx   = KW'(int'(col_idx_q) * ROWS + int'(row_idx_q));
    raw       = ~sample_q[row_idx_q];
    cnt_inc   = cnt_q[key_idx] + 4'd1;
    flip      = (state_q == EMIT) && (raw != key_state_q[key_idx]) && (cnt_inc == DEB_CNT);
    col_idx_d = (col_idx_q == COL_LAST) ? '0 : col_idx_q + CW'(1);
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  logic [5:0] rep_q [NK];
  logic       rep_next_q [NK];
  logic [5:0] rep_inc;
  logic       rep_hit;

  // rep_q counts frames since the last press event of a held key.
  always_comb begin
    rep_inc = rep_q[key_idx] + 6'd1;
    rep_hit = (state_q == EMIT) && key_state_q[key_idx] && !flip &&
              (rep_inc == (rep_next_q[key_idx] ? 6'(REPEAT_NEXT) : 6'(REPEAT_FIRST)));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NK; i++) begin
        rep_q[i]      <= '0;
        rep_next_q[i] <= 1'b0;
      end
    end else if (state_q == EMIT) begin
      if (flip || !key_state_q[key_idx]) begin
        rep_q[key_idx]      <= '0;
        rep_next_q[key_idx] <= 1'b0;
      end else if (rep_hit) begin
        rep_q[key_idx]      <= '0;
        rep_next_q[key_idx] <= 1'b1;
      end else begin
        rep_q[key_idx] <= rep_inc;
      end
    end
  end

  assign push      = flip || rep_hit;
  assign push_data = {key_idx, flip ? raw : 1'b1};
`else
  assign push      = flip;
  assign push_data = {key_idx, raw};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= SCAN;
      dwell_q     <= '0;
      row_idx_q   <= '0;
      col_idx_q   <= '0;
      col_q       <= '1;
      sample_q    <= '1;
      key_state_q <= '0;
      for (int i = 0; i < NK; i++) cnt_q[i] <= '0;
    end else begin
      col_q <= ~(COLS'(1) << col_idx_q);
      unique case (state_q)
        SCAN: begin
          if (dwell_q == DWELL_LAST) begin
            dwell_q <= '0;
            state_q <= SAMPLE;
          end else begin
            dwell_q <= dwell_q + DW'(1);
          end
        end
        SAMPLE: begin
          sample_q  <= row;
          row_idx_q <= '0;
          state_q   <= EMIT;
        end
        EMIT: begin
          if (raw == key_state_q[key_idx]) begin
            cnt_q[key_idx] <= '0;
          end else if (flip) begin
            key_state_q[key_idx] <= raw;
            cnt_q[key_idx]       <= '0;
          end else begin
            cnt_q[key_idx] <= cnt_inc;
          end
          if (row_idx_q == ROW_LAST) begin
            row_idx_q <= '0;
            col_idx_q <= col_idx_d;
            col_q     <= ~(COLS'(1) << col_idx_d);
            state_q   <= SCAN;
          end else begin
            row_idx_q <= row_idx_q + RW'(1);
          end
        end
        default: state_q <= SCAN;
      endcase
    end
  end

  assign evt_pop = evt_valid && evt_ready;
  // Dropped only when nothing leaves the FIFO in the same cycle.
  assign drop       = push && full && !evt_pop;
  assign overflow_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : overflow_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) overflow_q <= 1'b0;
    else        overflow_q <= overflow_d;
  end

  keypad_evt_fifo #(
    .WIDTH (KW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_evt_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (push),
    .wr_data_i (push_data),
    .rd_en_i   (evt_ready),
    .rd_data_o (head),
    .full_o    (full),
    .empty_o   (empty)
  );

  assign col       = col_q;
  assign key_state = key_state_q;
  assign evt_valid = !empty;
  assign evt_code  = head[KW:1];
  assign evt_press = head[0];
  assign overflow  = overflow_q;

endmodule

// File: doc/keypad_matrix_scanner.md
Name: keypad_matrix_scanner

Overview:
Parametrised successor to the team's 4x4 keypad scanner state machine.
- Scans an ROWS x COLS active-low key matrix one column at a time and debounces every key independently.
- Reports press and release events through a valid/ready event FIFO, and exposes the live debounced key map.
- Sits between the board keypad pins and the display/number-decode logic.

Parameters:
ROWS, 4, number of row inputs (sensed lines), 1..8
COLS, 4, number of column outputs (driven lines), 1..8
SCAN_DIV, 8, clock cycles each column is driven; must be >= ROWS+2
DEBOUNCE, 3, consecutive agreeing samples of a key required to change its debounced state, 1..15
FIFO_DEPTH, 4, event FIFO entries, power of two >= 2

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
row  in  ROWS  row sense lines, 0 = key closed on driven column; pre-synchronised externally
col  out  COLS  column drive, one-hot-low while scanning
key_state  out  ROWS*COLS  debounced map, bit k = col_idx*ROWS + row_idx, 1 = pressed
evt_valid  out  1  FIFO non-empty
evt_ready  in  1  consumer pops the head entry when evt_valid && evt_ready
evt_code  out  clog2(ROWS*COLS)  key index of the head event
evt_press  out  1  1 = press event, 0 = release event
overflow  out  1  sticky: an event was dropped because the FIFO was full
ovf_clr  in  1  clears overflow

Behaviour:
- Reset values (async, while reset=0): col all ones, key_state 0, FIFO empty, evt_valid 0, evt_code 0, evt_press 0, overflow 0, all debounce counters 0, FSM in SCAN with col_idx 0 and dwell 0.
- First clock after reset release drives col = ~(1<<0).
- FSM states:
  - SCAN: dwell counts 0..SCAN_DIV-ROWS-2, then go to SAMPLE.
  - SAMPLE (1 cycle): register row into a sample latch and go to EMIT with row_idx 0.
  - EMIT (ROWS cycles, one per row_idx):
    - Evaluate key k = col_idx*ROWS + row_idx.
    - If the raw sample (~row bit) equals key_state[k], clear that key's counter.
    - Otherwise increment the counter. When it reaches DEBOUNCE, flip key_state[k], clear the counter and push {k, new state}.
    - After row_idx ROWS-1, advance col_idx (wrap COLS-1 -> 0), update col registered, return to SCAN.
- Each column occupies exactly SCAN_DIV cycles; full frame = COLS*SCAN_DIV cycles.
- A press is reported DEBOUNCE frames after the closure first samples. Event push occurs in the EMIT cycle of that key; evt_valid rises the next cycle.
- Multiple keys (including in the same column) are tracked independently. Events are pushed in row order within a column and column order within a frame.
- FIFO rules:
  - Push when full without a pop in the same cycle: event dropped, overflow set.
  - Push and pop in the same cycle when full: both accepted, no drop.
  - Pop when empty: ignored.
  - Head fields are stable while evt_valid && !evt_ready.
- ovf_clr and an overflowing push in the same cycle: overflow stays 1 (set wins).
- Reset mid-frame: all state cleared immediately; held keys re-report as presses after DEBOUNCE frames.

Optional Feature:
KEYPAD_AUTOREPEAT_EN
- Defined: per-key repeat counter in frames. A key held pressed pushes an extra press event 32 frames after its press event, then every 8 frames, until release. Repeat pushes obey the same overflow rules.
- Undefined: exactly one press and one release event per debounced transition; no repeat logic synthesised.

Decomposition:
- Shared package keypad_pkg holds:
  - FSM state encodings (SCAN, SAMPLE, EMIT).
  - Key-index width function clog2.
  - Autorepeat constants REPEAT_FIRST=32, REPEAT_NEXT=8.
- One natural sub-module: keypad_evt_fifo, a synchronous FIFO parametrised by width and depth with full/empty and same-cycle push/pop.

Test Plan (defaults: ROWS=4, COLS=4, SCAN_DIV=8, DEBOUNCE=3, FIFO_DEPTH=4; frame = 32 cycles):
- Idle rows all ones for 10 frames -> col cycles 1110,1101,1011,0111 each 8 cycles; evt_valid never asserts; key_state 0.
- Close key col 1/row 2 (row=1011 whenever col=1101), held -> after 3 frames key_state[6]=1; one event code 6, press 1; evt_ready=1 pops it.
- Same key closed for 2 frames only -> no event, key_state[6] stays 0. Closed 3 frames then released -> press 6, then release 6 three frames later.
- evt_ready=0; press keys 0,5,10,15 and then 3 -> FIFO holds 0,5,10,15 in order; key 3 dropped; overflow=1. ovf_clr pulse -> overflow=0.
- Assert reset mid-EMIT with key 6 pressed -> outputs return to reset values asynchronously. After release, key 6 press re-reported 3 frames later.
- With KEYPAD_AUTOREPEAT_EN, hold key 9 for 60 frames -> press events at frames 3, 35, 43, 51, 59; release event 3 frames after release.
